// File: rtl/game_pkg.sv
// Shared definitions for the rhythm-game datapath: lane count, judge state
// encoding and the lives counter width.
package game_pkg;

    localparam int NUM_LANES = 3;
    localparam int LIVES_W   = 3;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_EVAL     = 2'd1,
        ST_REPORT   = 2'd2,
        ST_WAIT_LOW = 2'd3
    } judge_state_t;

endpackage

// File: rtl/key_press_latch.sv
// One lane of button capture: 2-FF synchronizer, falling-edge detect and a
// sticky press bit whose clear loses to a press detected in the same cycle.
module key_press_latch (
    input  logic clock,
    input  logic reset,
    input  logic key_n,
    input  logic clear,
    output logic pressed
);

    logic sync_1;
    logic sync_2;
    logic prev;
    logic fall;

    assign fall = prev & ~sync_2;

    always_ff @(posedge clock) begin
        if (!reset) begin
            sync_1  <= 1'b1;
            sync_2  <= 1'b1;
            prev    <= 1'b1;
            pressed <= 1'b0;
        end else begin
            sync_1 <= key_n;
            sync_2 <= sync_1;
            prev   <= sync_2;
            if (fall)
                pressed <= 1'b1;
            else if (clear)
                pressed <= 1'b0;
        end
    end

endmodule

// File: rtl/note_judge.sv
// Player-input judge: captures lane presses, judges them against the bottom
// note row on request, times the hit/miss feedback phase and keeps score.
//
// state       | meaning
// ST_IDLE     | waiting for check_en
// ST_EVAL     | judge captured presses against line_6
// ST_REPORT   | input_checked high, counters update, presses cleared
// ST_WAIT_LOW | wait for check_en to drop before re-arming
module note_judge
    import game_pkg::*;
#(
    parameter int FEEDBACK_CYCLES = 25_000_000,
    parameter int SCORE_W         = 10,
    parameter int LIVES_INIT      = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_LANES-1:0] key_n,
    input  logic                 check_en,
    input  logic [NUM_LANES-1:0] line_6,
    input  logic                 hit_en,
    input  logic                 miss_en,
    output logic                 input_checked,
    output logic                 hit,
    output logic                 miss,
    output logic                 hit_finish,
    output logic                 miss_finish,
    output logic [SCORE_W-1:0]   score,
    output logic [7:0]           streak,
    output logic [LIVES_W-1:0]   lives,
    output logic                 game_over
);

    localparam int CNT_W = $clog2(FEEDBACK_CYCLES + 1);

    judge_state_t         state;
    judge_state_t         state_next;
    logic [NUM_LANES-1:0] pressed;
    logic                 clear_pressed;
    logic [CNT_W-1:0]     fb_cnt;
    logic                 fb_at_end;

    assign clear_pressed = (state == ST_REPORT);

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        key_press_latch u_latch (
            .clock   (clock),
            .reset   (reset),
            .key_n   (key_n[i]),
            .clear   (clear_pressed),
            .pressed (pressed[i])
        );
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:     if (check_en) state_next = ST_EVAL;
            ST_EVAL:     state_next = ST_REPORT;
            ST_REPORT:   state_next = ST_WAIT_LOW;
            ST_WAIT_LOW: if (!check_en) state_next = ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state         <= ST_IDLE;
            input_checked <= 1'b0;
            hit           <= 1'b0;
            miss          <= 1'b0;
            score         <= '0;
            streak        <= '0;
            lives         <= LIVES_W'(LIVES_INIT);
            game_over     <= 1'b0;
        end else begin
            state         <= state_next;
            input_checked <= (state == ST_EVAL);
            if (state == ST_EVAL) begin
                hit  <= (line_6 != '0) && (pressed == line_6);
                miss <= (pressed != line_6);
            end
            // hit/miss are already registered by the time REPORT is reached
            if (state == ST_REPORT) begin
                if (hit) begin
                    if (!game_over && score != '1)
                        score <= score + SCORE_W'(1);
                    if (streak != 8'hFF)
                        streak <= streak + 8'd1;
                end else if (miss) begin
                    streak <= '0;
                    if (!game_over && lives != '0) begin
                        lives <= lives - LIVES_W'(1);
                        if (lives == LIVES_W'(1))
                            game_over <= 1'b1;
                    end
                end
            end
        end
    end

    // Counter runs one past the terminal value so the finish pulse fires once per phase.
    assign fb_at_end = (fb_cnt == CNT_W'(FEEDBACK_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (!reset) begin
            fb_cnt      <= '0;
            hit_finish  <= 1'b0;
            miss_finish <= 1'b0;
        end else begin
            if (!hit_en && !miss_en)
                fb_cnt <= '0;
            else if (fb_cnt != CNT_W'(FEEDBACK_CYCLES))
                fb_cnt <= fb_cnt + CNT_W'(1);
            hit_finish  <= hit_en && fb_at_end;
            miss_finish <= !hit_en && miss_en && fb_at_end;
        end
    end

endmodule
